regfile_write_arbiter: RTL and testbench

//   Shares the register file's single write port among NUM_REQ writers (0 = ALU writeback,
//   1 = memory load, 2 = debug), using round-robin arbitration.

---
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the register file's single write port among NUM_REQ writers
// (0 = ALU writeback, 1 = memory load, 2 = debug) with round-robin arbitration.
// The winning write is registered for one cycle before it reaches the register
// file. While it is in flight, it is forwarded onto the read port, so consumers
// see the new value one cycle early.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   req_valid      per-requester write request
//   req_ready      per-requester grant; one-hot or zero; combinational
//   req_addr       flattened; requester i at [i*ADDR_W +: ADDR_W]
//   req_data       flattened; requester i at [i*DATA_W +: DATA_W]
//   stall_in       high: issue no grants this cycle
//   rf_write_en    register_file write_en
//   rf_write_addr  register_file write_addr_in
//   rf_write_data  register_file write_data_in
//   rd_addr_in     read address (also drives register_file read_addr_in)
//   rf_read_data   register_file reg_b_out
//   rd_data_out    read data with the in-flight write forwarded
//   last_grant     index of the most recently accepted requester
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic                       stall_in,
    output logic                       rf_write_en,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    input  logic [ADDR_W-1:0]          rd_addr_in,
    input  logic [DATA_W-1:0]          rf_read_data,
    output logic [DATA_W-1:0]          rd_data_out,
    output logic [$clog2(NUM_REQ)-1:0] last_grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  rr_ptr;
    logic              wr_en_q;

    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Round-robin search. The first pass takes the lowest valid index at or
    // above rr_ptr. The second pass handles wrap-around and only matters when
    // the first pass found nothing, so it naturally picks from below rr_ptr.
    // Only req_valid feeds the search, so req_ready cannot loop back on itself.
    always_comb begin
        // NOTE: every variable gets a default before the search; a path that
        // leaves one unassigned would infer a latch.
        grant_any = 1'b0;
        grant_idx = '0;
        win_addr  = '0;
        win_data  = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(i);
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(i);
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
        end

        // The reset cycle and stalled cycles accept nothing.
        if (reset || stall_in) begin
            grant_any = 1'b0;
        end
    end

    assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

    // NOTE: all state updates use non-blocking assignments, so every register
    // samples the pre-edge values and the block's statement order does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q       <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            rr_ptr        <= '0;
            last_grant    <= '0;
        end else begin
            wr_en_q <= grant_any;
            if (grant_any) begin
                rf_write_addr <= win_addr;
                rf_write_data <= win_data;
                last_grant    <= grant_idx;
                rr_ptr        <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx + PTR_W'(1);
            end
        end
    end

    // A write registered just before reset is dropped during the reset cycle
    // itself, not only afterwards. The register file must never capture it.
    assign rf_write_en = wr_en_q && !reset;

    // Bypass: the register file still holds the old value while a write to
    // the same address is in flight.
    assign rd_data_out = (rf_write_en && (rf_write_addr == rd_addr_in)) ? rf_write_data
                                                                         : rf_read_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Stimulus side: holds each requester's pending write and drives it until it
// transfers. A reference arbiter predicts req_ready from a scan that starts at
// rr and wraps (modulo arithmetic). Each predicted transfer is pushed into a
// scoreboard. A monitor pops one entry whenever the DUT presents a write.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 3;
    localparam int PTR_W   = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic                      stall_in = 1'b0;
    logic                      rf_write_en;
    logic [ADDR_W-1:0]         rf_write_addr;
    logic [DATA_W-1:0]         rf_write_data;
    logic [ADDR_W-1:0]         rd_addr_in = '0;
    logic [DATA_W-1:0]         rf_read_data = '0;
    logic [DATA_W-1:0]         rd_data_out;
    logic [PTR_W-1:0]          last_grant;

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .stall_in     (stall_in),
        .rf_write_en  (rf_write_en),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .rd_addr_in   (rd_addr_in),
        .rf_read_data (rf_read_data),
        .rd_data_out  (rd_data_out),
        .last_grant   (last_grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    int checks   = 0;
    int failures = 0;

    wr_t sb[$];

    // Requester-side state
    bit                pend[NUM_REQ];
    logic [ADDR_W-1:0] paddr[NUM_REQ];
    logic [DATA_W-1:0] pdata[NUM_REQ];

    // Reference-model state
    int  rr_m     = 0;
    int  exp_last = 0;
    bit  cur_v    = 1'b0;
    wr_t cur_w;

    // Per-cycle controls
    bit                rst_s     = 1'b1;
    bit                stall_s   = 1'b0;
    bit                refill    = 1'b0;
    bit                force_rd  = 1'b0;
    logic [ADDR_W-1:0] forced_ra = '0;
    logic [DATA_W-1:0] forced_rd = '0;
    int                last_win  = -1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pend[i]  = 1'b1;
        paddr[i] = a;
        pdata[i] = d;
    endtask

    // One clock cycle: drive shortly after the rising edge, then check and
    // advance the model on the falling edge.
    task automatic step();
        logic [NUM_REQ-1:0] exp_ready;
        logic [DATA_W-1:0]  exp_rd;
        int                 win;

        @(posedge clk);
        #1;
        reset    = rst_s;
        stall_in = stall_s;
        if (rst_s) begin
            sb.delete();
            cur_v = 1'b0;
            rr_m  = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]                  = pend[i];
            req_addr[i*ADDR_W +: ADDR_W]  = paddr[i];
            req_data[i*DATA_W +: DATA_W]  = pdata[i];
        end
        if (force_rd) begin
            rd_addr_in   = forced_ra;
            rf_read_data = forced_rd;
        end else begin
            rd_addr_in   = (cur_v && $urandom_range(0, 1) == 1) ? cur_w.addr
                                                                : ADDR_W'($urandom);
            rf_read_data = DATA_W'($urandom);
        end

        @(negedge clk);
        win = -1;
        if (!rst_s && !stall_s) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (rr_m + k) % NUM_REQ;
                if (win < 0 && pend[idx]) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));

        exp_rd = (cur_v && cur_w.addr == rd_addr_in) ? cur_w.data : rf_read_data;
        check("rd_data_out", 32'(rd_data_out), 32'(exp_rd));
        check("last_grant", 32'(last_grant), 32'(exp_last));

        last_win = win;
        if (win >= 0) begin
            cur_w.addr = paddr[win];
            cur_w.data = pdata[win];
            cur_v      = 1'b1;
            sb.push_back(cur_w);
            pend[win]  = 1'b0;
            rr_m       = (win + 1) % NUM_REQ;
            exp_last   = win;
            if (refill) set_req(win, ADDR_W'($urandom), DATA_W'($urandom));
        end else begin
            cur_v = 1'b0;
        end
        if (rst_s) exp_last = 0;
    endtask

    // Monitor: after each rising edge (and after inputs settle), a presented
    // write must match the oldest scoreboard entry. With an empty scoreboard,
    // the DUT must present nothing.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            check("rf_write_en", 32'(rf_write_en), 32'(sb.size() > 0));
            if (rf_write_en && sb.size() > 0) begin
                e = sb.pop_front();
                check("rf_write_addr", 32'(rf_write_addr), 32'(e.addr));
                check("rf_write_data", 32'(rf_write_data), 32'(e.data));
            end
        end
    end

    initial begin
        int grant_seq[6];
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i]  = 1'b0;
            paddr[i] = '0;
            pdata[i] = '0;
        end

        // 1. Reset, then idle for 10 cycles.
        rst_s = 1'b1;
        repeat (2) step();
        rst_s = 1'b0;
        repeat (10) step();
        check("idle_addr", 32'(rf_write_addr), 32'h0);
        check("idle_data", 32'(rf_write_data), 32'h0);
        check("idle_last_grant", 32'(last_grant), 32'h0);

        // 2. Single request from requester 1.
        set_req(1, 3'd5, 8'hA7);
        step();
        check("single_grant_is_req1", 32'(last_win), 32'd1);
        repeat (2) step();

        // 3. All valid continuously, starting from rr=0.
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        refill = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'($urandom), DATA_W'($urandom));
        for (int c = 0; c < 6; c++) begin
            step();
            grant_seq[c] = last_win;
        end
        refill = 1'b0;
        for (int c = 0; c < 6; c++) check("rr_order", 32'(grant_seq[c]), 32'(c % 3));
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        repeat (2) step();

        // 4. Requester 0 writes addr 3 = 0x5C, then read addr 3 with stale data.
        set_req(0, 3'd3, 8'h5C);
        step();
        force_rd  = 1'b1;
        forced_ra = 3'd3;
        forced_rd = 8'h00;
        step();
        check("forward_value", 32'(rd_data_out), 32'h5C);
        force_rd = 1'b0;
        step();

        // 5. Requester 2 valid under a 3-cycle stall.
        set_req(2, 3'd0, 8'h3E);
        stall_s = 1'b1;
        repeat (3) step();
        stall_s = 1'b0;
        step();
        check("grant_after_stall", 32'(last_win), 32'd2);
        step();

        // 6. Transfer, then reset the next cycle: the write is dropped.
        set_req(1, 3'd6, 8'h91);
        step();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        step();
        set_req(1, 3'd6, 8'h91);
        set_req(2, 3'd2, 8'h44);
        step();
        check("rr_after_reset", 32'(last_win), 32'd1);
        step();

        // Randomized traffic with stalls and occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, ADDR_W'($urandom), DATA_W'($urandom));
            end
            stall_s = ($urandom_range(0, 4) == 0);
            rst_s   = ($urandom_range(0, 49) == 0);
            step();
        end
        rst_s   = 1'b0;
        stall_s = 1'b0;
        repeat (8) step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
